// File: rtl/regfile_write_arbiter_if.sv
// rtl/regfile_write_arbiter_if.sv - request and write-port signals for regfile_write_arbiter
interface regfile_write_arbiter_if;
    logic        wb_en;
    logic [4:0]  wb_rW;
    logic [31:0] wb_Wd;
    logic        wb_stall;
    logic        md_valid;
    logic [4:0]  md_rW;
    logic [31:0] md_Wd;
    logic        md_ready;
    logic        md_issue;
    logic [4:0]  md_issue_rd;
    logic        rf_en;
    logic [4:0]  rf_rW;
    logic [31:0] rf_Wd;
    logic [31:0] pending_mask;

    modport master (
        output wb_en, wb_rW, wb_Wd,
        output md_valid, md_rW, md_Wd,
        output md_issue, md_issue_rd,
        input  wb_stall, md_ready,
        input  rf_en, rf_rW, rf_Wd, pending_mask
    );

    modport slave (
        input  wb_en, wb_rW, wb_Wd,
        input  md_valid, md_rW, md_Wd,
        input  md_issue, md_issue_rd,
        output wb_stall, md_ready,
        output rf_en, rf_rW, rf_Wd, pending_mask
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - shares one register-file write port between writeback and mul/div
module regfile_write_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input logic                   clk,
    input logic                   rst,
    regfile_write_arbiter_if.slave bus
);

    localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]  r_cnt;
    logic        r_rf_en;
    logic [4:0]  r_rf_rW;
    logic [31:0] r_rf_Wd;
    logic [31:0] r_pending;

    logic        w_force;
    logic        w_wb_grant;
    logic        w_md_grant;
    logic        w_wb_stall;
    logic        w_wr_en;
    logic [4:0]  w_wr_rW;
    logic [31:0] w_wr_Wd;
    logic [3:0]  w_cnt_next;
    logic [31:0] w_set;
    logic [31:0] w_clr;
    logic [31:0] w_pending_next;

    // Grants are suppressed during reset so nothing handshakes while the state is being cleared.
    always_comb begin
        w_force    = 1'b0;
        w_wb_grant = 1'b0;
        w_md_grant = 1'b0;
        w_wb_stall = 1'b0;
        if (!rst) begin
            w_force = bus.md_valid && (r_cnt == LP_LIMIT);
            if (w_force) begin
                w_md_grant = 1'b1;
                w_wb_stall = bus.wb_en;
            end else if (bus.wb_en) begin
                w_wb_grant = 1'b1;
            end else if (bus.md_valid) begin
                w_md_grant = 1'b1;
            end
        end
    end

    // Register 0 grants still complete the handshake but never reach the write port.
    always_comb begin
        w_wr_rW = 5'd0;
        w_wr_Wd = 32'd0;
        if (w_md_grant) begin
            w_wr_rW = bus.md_rW;
            w_wr_Wd = bus.md_Wd;
        end else if (w_wb_grant) begin
            w_wr_rW = bus.wb_rW;
            w_wr_Wd = bus.wb_Wd;
        end
        w_wr_en = (w_md_grant || w_wb_grant) && (w_wr_rW != 5'd0);
    end

    always_comb begin
        w_cnt_next = 4'd0;
        if (bus.md_valid && !w_md_grant) begin
            w_cnt_next = (r_cnt == LP_LIMIT) ? r_cnt : r_cnt + 4'd1;
        end
    end

    // A same-cycle issue and retire to one register leaves it pending: set is applied after clear.
    always_comb begin
        w_set = 32'd0;
        w_clr = 32'd0;
        if (bus.md_issue && (bus.md_issue_rd != 5'd0)) begin
            w_set = 32'd1 << bus.md_issue_rd;
        end
        if (w_md_grant) begin
            w_clr = 32'd1 << bus.md_rW;
        end
        w_pending_next = ((r_pending & ~w_clr) | w_set) & ~32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= 4'd0;
            r_rf_en   <= 1'b0;
            r_rf_rW   <= 5'd0;
            r_rf_Wd   <= 32'd0;
            r_pending <= 32'd0;
        end else begin
            r_cnt     <= w_cnt_next;
            r_rf_en   <= w_wr_en;
            r_pending <= w_pending_next;
            if (w_wr_en) begin
                r_rf_rW <= w_wr_rW;
                r_rf_Wd <= w_wr_Wd;
            end
        end
    end

    assign bus.wb_stall     = w_wb_stall;
    assign bus.md_ready     = w_md_grant;
    assign bus.rf_en        = r_rf_en;
    assign bus.rf_rW        = r_rf_rW;
    assign bus.rf_Wd        = r_rf_Wd;
    assign bus.pending_mask = r_pending;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - directed scoreboard bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

    typedef struct {
        logic        en;
        logic [4:0]  rW;
        logic [31:0] Wd;
    } wr_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    wr_t  sb[$];
    wr_t  rec;
    logic [4:0]  m_rW;
    logic [31:0] m_Wd;

    regfile_write_arbiter_if bus ();

    regfile_write_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                         input logic mv, input logic [4:0] mr, input logic [31:0] md,
                         input logic mi, input logic [4:0] mir);
        bus.wb_en       = we;
        bus.wb_rW       = wr;
        bus.wb_Wd       = wd;
        bus.md_valid    = mv;
        bus.md_rW       = mr;
        bus.md_Wd       = md;
        bus.md_issue    = mi;
        bus.md_issue_rd = mir;
    endtask

    // One clock cycle: check handshake outputs, push expected write, then compare the write port.
    task automatic cyc(input string tag, input logic exp_rdy, input logic exp_stall,
                       input logic exp_en, input logic [4:0] exp_rW, input logic [31:0] exp_Wd);
        wr_t r;
        #1;
        chk({tag, ".md_ready"}, 32'(bus.md_ready), 32'(exp_rdy));
        chk({tag, ".wb_stall"}, 32'(bus.wb_stall), 32'(exp_stall));
        if (exp_en) begin
            m_rW = exp_rW;
            m_Wd = exp_Wd;
        end
        r.en = exp_en;
        r.rW = m_rW;
        r.Wd = m_Wd;
        sb.push_back(r);
        @(posedge clk);
        #1;
        rec = sb.pop_front();
        chk({tag, ".rf_en"}, 32'(bus.rf_en), 32'(rec.en));
        chk({tag, ".rf_rW"}, 32'(bus.rf_rW), 32'(rec.rW));
        chk({tag, ".rf_Wd"}, bus.rf_Wd, rec.Wd);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        m_rW   = 5'd0;
        m_Wd   = 32'd0;
        rst    = 1'b1;
        drive(1'b1, 5'd5, 32'h55, 1'b1, 5'd6, 32'h66, 1'b1, 5'd7);
        #1;
        chk("rst.md_ready", 32'(bus.md_ready), 32'd0);
        chk("rst.wb_stall", 32'(bus.wb_stall), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst.rf_en", 32'(bus.rf_en), 32'd0);
        chk("rst.rf_rW", 32'(bus.rf_rW), 32'd0);
        chk("rst.rf_Wd", bus.rf_Wd, 32'd0);
        chk("rst.pending", bus.pending_mask, 32'd0);

        // First cycle after release: WB only
        rst = 1'b0;
        drive(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        cyc("wb_only", 1'b0, 1'b0, 1'b1, 5'd5, 32'h1234);

        // MD only: issue then retire register 9
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
        cyc("md_issue", 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("md_issue.pending", bus.pending_mask, 32'h200);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'hCAFE, 1'b0, 5'd0);
        cyc("md_only", 1'b1, 1'b0, 1'b1, 5'd9, 32'hCAFE);
        chk("md_only.pending", bus.pending_mask, 32'h0);

        // Starvation: four refusals, forced fifth, WB back on sixth
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'd7, 32'hA0 + 32'(i), 1'b1, 5'd12, 32'hBEEF, 1'b0, 5'd0);
            cyc("starve_wb", 1'b0, 1'b0, 1'b1, 5'd7, 32'hA0 + 32'(i));
        end
        drive(1'b1, 5'd7, 32'hB5, 1'b1, 5'd12, 32'hBEEF, 1'b0, 5'd0);
        cyc("starve_force", 1'b1, 1'b1, 1'b1, 5'd12, 32'hBEEF);
        drive(1'b1, 5'd7, 32'hB5, 1'b1, 5'd12, 32'hBEE2, 1'b0, 5'd0);
        cyc("starve_wb_again", 1'b0, 1'b0, 1'b1, 5'd7, 32'hB5);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hBEE2, 1'b0, 5'd0);
        cyc("md_after_wb", 1'b1, 1'b0, 1'b1, 5'd12, 32'hBEE2);

        // Register 0 handling on both sources
        drive(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0);
        cyc("wb_r0", 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("r0.pending", bus.pending_mask, 32'h0);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1111, 1'b0, 5'd0);
        cyc("md_r0", 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        cyc("idle", 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);

        // Same-cycle issue and retire of register 3: set wins
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3);
        cyc("issue3", 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("issue3.pending", bus.pending_mask, 32'h8);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h33, 1'b1, 5'd3);
        cyc("issue_retire3", 1'b1, 1'b0, 1'b1, 5'd3, 32'h33);
        chk("issue_retire3.pending", bus.pending_mask, 32'h8);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h44, 1'b0, 5'd0);
        cyc("retire3", 1'b1, 1'b0, 1'b1, 5'd3, 32'h44);
        chk("retire3.pending", bus.pending_mask, 32'h0);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd20, 32'h2020, 1'b0, 5'd0);
        cyc("md_not_pending", 1'b1, 1'b0, 1'b1, 5'd20, 32'h2020);

        // Build pending_mask=0x0F0 and cnt=2, then reset between edges
        for (int i = 4; i < 8; i++) begin
            drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'(i));
            cyc("issue_hi", 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        end
        chk("pre_rst.pending", bus.pending_mask, 32'hF0);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 5'd8, 32'h80 + 32'(i), 1'b1, 5'd4, 32'h4444, 1'b0, 5'd0);
            cyc("pre_rst_wb", 1'b0, 1'b0, 1'b1, 5'd8, 32'h80 + 32'(i));
        end
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst.rf_en", 32'(bus.rf_en), 32'd0);
        chk("async_rst.rf_rW", 32'(bus.rf_rW), 32'd0);
        chk("async_rst.rf_Wd", bus.rf_Wd, 32'd0);
        chk("async_rst.pending", bus.pending_mask, 32'd0);
        chk("async_rst.md_ready", 32'(bus.md_ready), 32'd0);
        chk("async_rst.wb_stall", 32'(bus.wb_stall), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_edge.rf_en", 32'(bus.rf_en), 32'd0);
        m_rW = 5'd0;
        m_Wd = 32'd0;
        rst  = 1'b0;

        // Counter must restart from 0: four refusals before the force
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'd8, 32'hC0 + 32'(i), 1'b1, 5'd4, 32'h4444, 1'b0, 5'd0);
            cyc("post_rst_wb", 1'b0, 1'b0, 1'b1, 5'd8, 32'hC0 + 32'(i));
        end
        drive(1'b1, 5'd8, 32'hC9, 1'b1, 5'd4, 32'h4444, 1'b0, 5'd0);
        cyc("post_rst_force", 1'b1, 1'b1, 1'b1, 5'd4, 32'h4444);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        cyc("final_idle", 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive cycles a muldiv request may be refused before it is forced through (legal range 1..15).
REQ-002 clk  input  1  system clock; all state updates on posedge clk.
REQ-003 rst  input  1  asynchronous active-high reset; takes effect immediately and does not wait for a clock edge.
REQ-004 wb_en  input  1  pipeline writeback request.
REQ-005 wb_rW  input  5  pipeline destination register.
REQ-006 wb_Wd  input  32  pipeline write data.
REQ-007 wb_stall  output  1  pipeline must hold its writeback this cycle (combinational).
REQ-008 md_valid  input  1  mul/div result request.
REQ-009 md_rW  input  5  mul/div destination register.
REQ-010 md_Wd  input  32  mul/div result data.
REQ-011 md_ready  output  1  mul/div result accepted this cycle (combinational).
REQ-012 md_issue  input  1  mul/div operation issued; marks its destination pending.
REQ-013 md_issue_rd  input  5  destination of the issued operation.
REQ-014 rf_en  output  1  register-file write enable (registered).
REQ-015 rf_rW  output  5  register-file write address (registered).
REQ-016 rf_Wd  output  32  register-file write data (registered).
REQ-017 pending_mask  output  32  bit i set = register i awaits a mul/div result (registered).

Function
REQ-018 The single register-file write port is shared between the pipeline (WB) and the mul/div unit (MD), with at most one grant per cycle.
REQ-019 Starvation counter cnt (4 bits) increments each cycle that md_valid=1 and md_ready=0, saturates at STARVE_LIMIT, and clears to 0 on any MD transfer or when md_valid=0.
REQ-020 force = md_valid & (cnt == STARVE_LIMIT).
REQ-021 Grant rules: force -> MD granted, wb_stall = wb_en; else wb_en=1 -> WB granted, md_ready=0, wb_stall=0; else md_valid=1 -> MD granted.
REQ-022 md_ready = 1 exactly when MD is granted; an MD transfer is md_valid & md_ready.
REQ-023 A WB write accepted in cycle T (wb_en & !wb_stall) appears on rf_en/rf_rW/rf_Wd in cycle T+1; an MD transfer in cycle T appears likewise in T+1; write latency is one cycle.
REQ-024 A granted request whose destination is register 0 is consumed (handshake completes) but produces rf_en=0 in T+1.
REQ-025 With no grant, or only a register-0 grant, in cycle T: rf_en=0 in T+1; rf_rW and rf_Wd then hold their previous values.
REQ-026 pending_mask: md_issue with md_issue_rd!=0 sets bit md_issue_rd; an MD transfer clears bit md_rW; when set and clear target the same bit in one cycle, set wins; bit 0 is never set.
REQ-027 MD transfers are accepted whether or not the md_rW bit is set; pending_mask is tracked but never used to block a transfer.
REQ-028 WB and MD requests to the same register are serialized purely by REQ-021; the later-granted write lands last.
REQ-029 wb_stall=1 only when wb_en=1 and force=1; a stalled WB request must be held stable and is granted in the next non-forced cycle.

Reset
REQ-030 While rst=1: rf_en=0, rf_rW=0, rf_Wd=0, pending_mask=0, cnt=0.
REQ-031 Outputs wb_stall and md_ready evaluate to 0 while rst=1.
REQ-032 An MD or WB transfer in the cycle that reset asserts is discarded and no write is produced.
REQ-033 The first grant is possible in the first cycle after rst deasserts.

Verification
REQ-034 WB only: wb_en=1, wb_rW=5, wb_Wd=0x1234 at T -> rf_en=1, rf_rW=5, rf_Wd=0x1234 at T+1; md_ready=0.
REQ-035 MD only: issue rd=9 at T0 -> pending_mask=0x200; md_valid, md_rW=9, md_Wd=0xCAFE at T1 -> md_ready=1; write visible at T2 and pending_mask=0 from T2.
REQ-036 Starvation with STARVE_LIMIT=4: wb_en and md_valid held high -> md_ready=0 for 4 cycles, then md_ready=1 and wb_stall=1 in the 5th cycle; WB is granted again in the 6th cycle.
REQ-037 Register 0: wb_en=1, wb_rW=0 -> rf_en=0 next cycle; md_issue rd=0 -> pending_mask stays 0.
REQ-038 Simultaneous events: md_issue rd=3 and an MD transfer to rd=3 in the same cycle -> bit 3 remains set.
REQ-039 Reset mid-operation: pending_mask=0x0F0 and cnt=2, then rst pulsed between clock edges -> all registered outputs are 0 immediately, without waiting for a clock edge.
